// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection and a saturating
// counter of inserted bubbles.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset (loads the bubble state)
//   ID_*           decoded instruction from the decode stage
//   flush          squash the instruction entering EX (taken branch/jump)
//   mem_stall      downstream memory not ready; freezes the register
//   EX_*           registered instruction presented to the execute stage
//   hazard_stall   combinational; freezes PC and IF/ID while a load-use
//                  bubble is being inserted
//   stall_count    saturating count of inserted load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ID_valid,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic [4:0] ID_rd,
    input  logic [7:0] ID_rs_data,
    input  logic [7:0] ID_rt_data,
    input  logic [7:0] ID_imm,
    input  logic       ID_RegWrite,
    input  logic       ID_MemRead,
    input  logic       ID_MemWrite,
    input  logic       ID_ALUSrc,
    input  logic       ID_uses_rt,
    input  logic [3:0] ID_ALUop,
    input  logic       flush,
    input  logic       mem_stall,
    output logic       EX_valid,
    output logic       EX_RegWrite,
    output logic       EX_MemRead,
    output logic       EX_MemWrite,
    output logic       EX_ALUSrc,
    output logic [4:0] EX_rs,
    output logic [4:0] EX_rt,
    output logic [4:0] EX_rd,
    output logic [7:0] EX_rs_data,
    output logic [7:0] EX_rt_data,
    output logic [7:0] EX_imm,
    output logic [3:0] EX_ALUop,
    output logic       hazard_stall,
    output logic [7:0] stall_count
);

    // Register index 31 means "no register" and never creates a dependency.
    localparam logic [4:0] NO_REG = 5'd31;

    logic       r_valid, r_reg_write, r_mem_read, r_mem_write, r_alu_src;
    logic [4:0] r_rs, r_rt, r_rd;
    logic [7:0] r_rs_data, r_rt_data, r_imm;
    logic [3:0] r_alu_op;
    logic [7:0] r_stall_count;

    logic       w_valid, w_reg_write, w_mem_read, w_mem_write, w_alu_src;
    logic [4:0] w_rs, w_rt, w_rd;
    logic [7:0] w_rs_data, w_rt_data, w_imm;
    logic [3:0] w_alu_op;

    logic       w_rs_match, w_rt_match, w_raw_hz;
    logic       w_bubble, w_hold;

    // Load-use detection against the instruction currently in EX.
    assign w_rs_match = (r_rd == ID_rs) && (ID_rs != NO_REG);
    assign w_rt_match = ID_uses_rt && (r_rd == ID_rt) && (ID_rt != NO_REG);
    assign w_raw_hz   = ID_valid && r_valid && r_mem_read && (r_rd != NO_REG)
                        && (w_rs_match || w_rt_match);

    // A flush or a memory stall takes precedence, so no bubble request then.
    assign hazard_stall = w_raw_hz && !flush && !mem_stall;

    // Flush always squashes; otherwise a memory stall freezes the register.
    // An invalid decode slot is captured as a bubble so that stale control
    // bits can never act in EX.
    assign w_hold   = mem_stall && !flush;
    assign w_bubble = flush || (!mem_stall && (w_raw_hz || !ID_valid));

    always_comb begin
        w_valid     = r_valid;
        w_reg_write = r_reg_write;
        w_mem_read  = r_mem_read;
        w_mem_write = r_mem_write;
        w_alu_src   = r_alu_src;
        w_alu_op    = r_alu_op;
        w_rs        = r_rs;
        w_rt        = r_rt;
        w_rd        = r_rd;
        w_rs_data   = r_rs_data;
        w_rt_data   = r_rt_data;
        w_imm       = r_imm;
        if (w_bubble) begin
            w_valid     = 1'b0;
            w_reg_write = 1'b0;
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_alu_src   = 1'b0;
            w_alu_op    = 4'd0;
            w_rs        = NO_REG;
            w_rt        = NO_REG;
            w_rd        = NO_REG;
            w_rs_data   = 8'd0;
            w_rt_data   = 8'd0;
            w_imm       = 8'd0;
        end else if (!w_hold) begin
            w_valid     = ID_valid;
            w_reg_write = ID_RegWrite;
            w_mem_read  = ID_MemRead;
            w_mem_write = ID_MemWrite;
            w_alu_src   = ID_ALUSrc;
            w_alu_op    = ID_ALUop;
            w_rs        = ID_rs;
            w_rt        = ID_rt;
            w_rd        = ID_rd;
            w_rs_data   = ID_rs_data;
            w_rt_data   = ID_rt_data;
            w_imm       = ID_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_alu_src   <= 1'b0;
            r_alu_op    <= 4'd0;
            r_rs        <= NO_REG;
            r_rt        <= NO_REG;
            r_rd        <= NO_REG;
            r_rs_data   <= 8'd0;
            r_rt_data   <= 8'd0;
            r_imm       <= 8'd0;
        end else begin
            r_valid     <= w_valid;
            r_reg_write <= w_reg_write;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_alu_src   <= w_alu_src;
            r_alu_op    <= w_alu_op;
            r_rs        <= w_rs;
            r_rt        <= w_rt;
            r_rd        <= w_rd;
            r_rs_data   <= w_rs_data;
            r_rt_data   <= w_rt_data;
            r_imm       <= w_imm;
        end
    end

    // Counts only bubbles actually inserted for load-use; holds at 255.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= 8'd0;
        end else if (hazard_stall && (r_stall_count != 8'hFF)) begin
            r_stall_count <= r_stall_count + 8'd1;
        end
    end

    assign EX_valid    = r_valid;
    assign EX_RegWrite = r_reg_write;
    assign EX_MemRead  = r_mem_read;
    assign EX_MemWrite = r_mem_write;
    assign EX_ALUSrc   = r_alu_src;
    assign EX_ALUop    = r_alu_op;
    assign EX_rs       = r_rs;
    assign EX_rt       = r_rt;
    assign EX_rd       = r_rd;
    assign EX_rs_data  = r_rs_data;
    assign EX_rt_data  = r_rt_data;
    assign EX_imm      = r_imm;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic [3:0] aluop;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [7:0] rs_data;
        logic [7:0] rt_data;
        logic [7:0] imm;
    } ex_t;

    typedef struct {
        ex_t        ex;
        logic       hz;
        logic [7:0] cnt;
        string      name;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ID_valid, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_uses_rt;
    logic [4:0] ID_rs, ID_rt, ID_rd;
    logic [7:0] ID_rs_data, ID_rt_data, ID_imm;
    logic [3:0] ID_ALUop;
    logic       flush, mem_stall;
    logic       EX_valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc;
    logic [4:0] EX_rs, EX_rt, EX_rd;
    logic [7:0] EX_rs_data, EX_rt_data, EX_imm;
    logic [3:0] EX_ALUop;
    logic       hazard_stall;
    logic [7:0] stall_count;

    rec_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    ex_t  cur_ex;
    logic [7:0] cur_cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ID_valid(ID_valid), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
        .ID_rs_data(ID_rs_data), .ID_rt_data(ID_rt_data), .ID_imm(ID_imm),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_ALUSrc(ID_ALUSrc), .ID_uses_rt(ID_uses_rt), .ID_ALUop(ID_ALUop),
        .flush(flush), .mem_stall(mem_stall),
        .EX_valid(EX_valid), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite), .EX_ALUSrc(EX_ALUSrc),
        .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
        .EX_rs_data(EX_rs_data), .EX_rt_data(EX_rt_data), .EX_imm(EX_imm),
        .EX_ALUop(EX_ALUop), .hazard_stall(hazard_stall), .stall_count(stall_count)
    );

    function automatic ex_t mk(input logic v, rw, mr, mw, as, input logic [3:0] op,
                               input logic [4:0] rs, rt, rd,
                               input logic [7:0] rsd, rtd, imm);
        ex_t e;
        e = '{v, rw, mr, mw, as, op, rs, rt, rd, rsd, rtd, imm};
        return e;
    endfunction

    localparam ex_t BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd31, 5'd31, 5'd31,
                               8'd0, 8'd0, 8'd0};

    // Scoreboard monitor: mid-cycle, after inputs have settled.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            rec_t r;
            ex_t  act;
            r   = sb.pop_front();
            act = '{EX_valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_ALUop,
                    EX_rs, EX_rt, EX_rd, EX_rs_data, EX_rt_data, EX_imm};
            n_checks++;
            if (act === r.ex) n_pass++;
            else $display("FAIL %s ex_state: got %h want %h", r.name, act, r.ex);
            n_checks++;
            if (hazard_stall === r.hz) n_pass++;
            else $display("FAIL %s hazard_stall: got %b want %b", r.name, hazard_stall, r.hz);
            n_checks++;
            if (stall_count === r.cnt) n_pass++;
            else $display("FAIL %s stall_count: got %0d want %0d", r.name, stall_count, r.cnt);
        end
    end

    task automatic drive(input ex_t id, input logic ut, fl, ms, rn);
        ID_valid    = id.valid;   ID_RegWrite = id.regwrite;
        ID_MemRead  = id.memread; ID_MemWrite = id.memwrite;
        ID_ALUSrc   = id.alusrc;  ID_ALUop    = id.aluop;
        ID_rs       = id.rs;      ID_rt       = id.rt;  ID_rd = id.rd;
        ID_rs_data  = id.rs_data; ID_rt_data  = id.rt_data; ID_imm = id.imm;
        ID_uses_rt  = ut; flush = fl; mem_stall = ms; rst_n = rn;
    endtask

    // One cycle: expect the current EX state and hazard_stall for the inputs
    // applied now; nxt/ncnt are what the coming edge must produce.
    task automatic cyc(input ex_t id, input logic ut, fl, ms, rn, hz,
                       input ex_t nxt, input logic [7:0] ncnt, input string name);
        rec_t r;
        @(posedge clk);
        #1;
        r.ex = cur_ex; r.hz = hz; r.cnt = cur_cnt; r.name = name;
        sb.push_back(r);
        drive(id, ut, fl, ms, rn);
        cur_ex  = nxt;
        cur_cnt = ncnt;
    endtask

    ex_t ld5, ld7, ld31, cons, dep7, inv7, m3, f1, f2, f3, g, rnd, any31;
    logic [7:0] k;

    initial begin
        ld5   = mk(1,1,1,0,1,4'h2, 5'd1, 5'd2, 5'd5, 8'h11, 8'h22, 8'h04);
        cons  = mk(1,1,0,0,0,4'h3, 5'd5, 5'd9, 5'd6, 8'h33, 8'h44, 8'h00);
        ld7   = mk(1,1,1,0,1,4'h2, 5'd1, 5'd2, 5'd7, 8'h55, 8'h66, 8'h08);
        dep7  = mk(1,1,0,0,0,4'h5, 5'd3, 5'd7, 5'd8, 8'h77, 8'h88, 8'h00);
        inv7  = mk(0,1,1,0,0,4'h1, 5'd7, 5'd7, 5'd9, 8'h99, 8'hAA, 8'h01);
        ld31  = mk(1,0,1,0,1,4'h2, 5'd1, 5'd2, 5'd31, 8'h01, 8'h02, 8'h03);
        any31 = mk(1,1,0,0,0,4'h6, 5'd31, 5'd31, 5'd10, 8'hBB, 8'hCC, 8'h00);
        m3    = mk(1,1,0,0,1,4'h4, 5'd12, 5'd13, 5'd3, 8'h12, 8'h34, 8'hA5);
        f1    = mk(1,1,1,1,1,4'hF, 5'd3, 5'd3, 5'd20, 8'hF1, 8'hF2, 8'hF3);
        f2    = mk(1,0,0,1,0,4'hE, 5'd21, 5'd22, 5'd23, 8'hE1, 8'hE2, 8'hE3);
        f3    = mk(1,1,0,0,1,4'hD, 5'd24, 5'd25, 5'd26, 8'hD1, 8'hD2, 8'hD3);
        g     = mk(1,1,0,1,0,4'h7, 5'd14, 5'd15, 5'd16, 8'h5A, 8'h6B, 8'h7C);

        rnd = ex_t'({$urandom, $urandom_range(65535, 0)});
        drive(rnd, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        cur_ex = BUBBLE; cur_cnt = 8'd0;

        // Second reset edge with random inputs.
        rnd = ex_t'({$urandom, $urandom_range(65535, 0)});
        cyc(rnd,   1, 0, 0, 0, 0, BUBBLE, 8'd0, "reset");
        // Load-use via rs.
        cyc(ld5,   0, 0, 0, 1, 0, ld5,    8'd0, "load5");
        cyc(cons,  0, 0, 0, 1, 1, BUBBLE, 8'd1, "use_rs");
        cyc(cons,  0, 0, 0, 1, 0, cons,   8'd1, "consumer_loads");
        // rt gating.
        cyc(ld7,   0, 0, 0, 1, 0, ld7,    8'd1, "load7");
        cyc(dep7,  0, 0, 0, 1, 0, dep7,   8'd1, "rt_unused");
        cyc(ld7,   0, 0, 0, 1, 0, ld7,    8'd1, "load7b");
        cyc(dep7,  1, 0, 0, 1, 1, BUBBLE, 8'd2, "rt_used");
        cyc(dep7,  1, 0, 0, 1, 0, dep7,   8'd2, "rt_consumer");
        // EX_rd = 31 never hazards.
        cyc(ld31,  1, 0, 0, 1, 0, ld31,   8'd2, "load31");
        cyc(any31, 1, 0, 0, 1, 0, any31,  8'd2, "rd31_nohz");
        // Invalid decode slot: no hazard, captured as bubble.
        cyc(ld7,   1, 0, 0, 1, 0, ld7,    8'd2, "load7c");
        cyc(inv7,  1, 0, 0, 1, 0, BUBBLE, 8'd2, "invalid_slot");
        // Flush beats mem_stall and hazard.
        cyc(ld5,   0, 0, 0, 1, 0, ld5,    8'd2, "load5b");
        cyc(cons,  0, 1, 1, 1, 0, BUBBLE, 8'd2, "flush_prio");
        // mem_stall over a pending hazard holds, then the bubble follows.
        cyc(ld5,   0, 0, 0, 1, 0, ld5,    8'd2, "load5c");
        cyc(cons,  0, 0, 1, 1, 0, ld5,    8'd2, "mstall_over_hz");
        cyc(cons,  0, 0, 0, 1, 1, BUBBLE, 8'd3, "hz_after_mstall");
        cyc(cons,  0, 0, 0, 1, 0, cons,   8'd3, "consumer_loads2");
        // mem_stall hold for three cycles.
        cyc(m3,    1, 0, 0, 1, 0, m3,     8'd3, "load_m3");
        cyc(f1,    1, 0, 1, 1, 0, m3,     8'd3, "hold1");
        cyc(f2,    1, 0, 1, 1, 0, m3,     8'd3, "hold2");
        cyc(f3,    1, 0, 1, 1, 0, m3,     8'd3, "hold3");
        cyc(g,     1, 0, 0, 1, 0, g,      8'd3, "release");
        // Reset mid-stall, then first edge after reset loads normally.
        cyc(ld5,   0, 0, 0, 1, 0, ld5,    8'd3, "load5d");
        cyc(cons,  0, 0, 0, 0, 1, BUBBLE, 8'd0, "reset_midstall");
        cyc(cons,  0, 0, 0, 1, 0, cons,   8'd0, "post_reset_load");
        // Saturation: 260 load-use bubbles.
        k = 8'd0;
        for (int i = 0; i < 260; i++) begin
            cyc(ld5,  0, 0, 0, 1, 0, ld5,    k, "sat_load");
            k = (k == 8'd255) ? 8'd255 : k + 8'd1;
            cyc(cons, 0, 0, 0, 1, 1, BUBBLE, k, "sat_use");
        end
        cyc(g,     0, 0, 0, 0, 0, BUBBLE, 8'd0, "sat_reset");
        cyc(g,     0, 0, 0, 1, 0, g,      8'd0, "after_sat_reset");
        cyc(g,     0, 0, 0, 1, 0, g,      8'd0, "final");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset; synchronous, active-low.
REQ-003 ID_valid  input  1  decode stage holds a real instruction.
REQ-004 ID_rs, ID_rt, ID_rd  input  5 each  decoded register indices; index 31 = no register.
REQ-005 ID_rs_data, ID_rt_data, ID_imm  input  8 each  register-file read data and immediate.
REQ-006 ID_RegWrite, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_uses_rt  input  1 each  decoded controls; ID_uses_rt marks rt as a source operand.
REQ-007 ID_ALUop  input  4  ALU operation code.
REQ-008 flush  input  1  squashes the instruction entering EX (taken branch/jump).
REQ-009 mem_stall  input  1  downstream memory not ready; freezes this register.
REQ-010 EX_valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc  output  1 each  registered controls.
REQ-011 EX_rs, EX_rt, EX_rd  output  5 each  registered indices, consumed by the forwarding unit.
REQ-012 EX_rs_data, EX_rt_data, EX_imm  output  8 each  registered operands.
REQ-013 EX_ALUop  output  4  registered ALU op.
REQ-014 hazard_stall  output  1  combinational; freezes PC and IF/ID when high.
REQ-015 stall_count  output  8  saturating count of inserted load-use bubbles.

Function
REQ-016 Load-use hazard: raw_hz = ID_valid & EX_valid & EX_MemRead & (EX_rd != 31) & ((EX_rd == ID_rs & ID_rs != 31) | (ID_uses_rt & EX_rd == ID_rt & ID_rt != 31)).
REQ-017 hazard_stall = raw_hz & ~flush & ~mem_stall; asserted in the same cycle as the condition, no registering.
REQ-018 Per-edge update priority: reset > flush > mem_stall > raw_hz > normal load.
REQ-019 flush: next-state is a bubble, irrespective of mem_stall or raw_hz.
REQ-020 mem_stall (no flush): every EX_* output holds its current value; stall_count unchanged.
REQ-021 raw_hz (no flush, no mem_stall): next-state is a bubble; stall_count increments by 1, saturating at 255.
REQ-022 Normal load: every EX_* output takes its ID_* counterpart; EX_valid takes ID_valid.
REQ-023 Bubble: EX_valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc = 0; EX_ALUop = 0; EX_rs = EX_rt = EX_rd = 31; EX_rs_data, EX_rt_data, EX_imm = 0.
REQ-024 Normal load with ID_valid = 0: captured as a bubble per REQ-023, so no RegWrite/MemRead escapes from an invalid slot.
REQ-025 Latency: one cycle ID -> EX; a load-use pair has exactly one bubble between the load and its consumer.
REQ-026 Consecutive hazards: each cycle with raw_hz is re-evaluated; a bubble clears EX_MemRead, so one load produces at most one bubble.
REQ-027 No internal FSM beyond the pipeline register and counter; no multi-cycle state.

Reset
REQ-028 rst_n low at a clock edge loads the bubble state of REQ-023 into all EX_* outputs and sets stall_count = 0, overriding flush and mem_stall.
REQ-029 Reset asserted mid-stall: on the next edge the bubble state is loaded and hazard_stall drops, because EX_valid = 0.
REQ-030 After rst_n rises, the first edge performs a normal load.

Verification
REQ-031 Reset: hold rst_n = 0 for two edges with random ID inputs -> EX_valid = 0, EX_rd = 31, stall_count = 0.
REQ-032 Load-use stall:
- Setup: EX holds a load (EX_MemRead = 1, EX_rd = 5); ID has ID_rs = 5, ID_valid = 1.
- Response: hazard_stall = 1 that cycle.
- Next edge: EX_valid = 0, EX_rd = 31, stall_count = 1.
- Following edge (ID unchanged): the consumer loads normally.
REQ-033 rt gating:
- Setup: EX load with EX_rd = 7; ID_rt = 7.
- ID_uses_rt = 0 -> hazard_stall = 0.
- ID_uses_rt = 1 -> hazard_stall = 1.
- EX_rd = 31 -> hazard_stall = 0 in all cases.
REQ-034 Flush priority: flush = 1, mem_stall = 1 and raw_hz true together -> hazard_stall = 0; next edge gives a bubble; stall_count unchanged.
REQ-035 mem_stall hold: valid instruction in EX (EX_rd = 3, EX_imm = 8'hA5); mem_stall = 1 for 3 cycles with changing ID inputs -> EX outputs stay constant; released edge loads the current ID.
REQ-036 Counter saturation: force 260 load-use bubbles -> stall_count stops at 255; rst_n low for one edge -> 0.
